// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between I-fetch and D load/store; each access takes LAT+3 cycles, ack in E+2+LAT.
// Requesters hold req until their one-cycle ack; the ungranted side simply keeps waiting with req held.
module mem_port_arbiter #(
    parameter int LAT  = 2,
    parameter int PRIO = 0,
    parameter int AW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic          viol
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic          side_d;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } acc_t;

    state_t     state;
    state_t     state_nxt;
    acc_t       acc;
    acc_t       grant_acc;
    logic [3:0] cnt;
    logic       last_d;
    logic       grant_d;
    logic       wait_last;
    logic       granted_req;

    // Round-robin ties go to the side that did not win last; fixed mode always favours D.
    always_comb begin
        grant_d = d_req && (!i_req || (PRIO == 0) || !last_d);
        grant_acc.side_d = grant_d;
        grant_acc.we     = grant_d && d_we;
        grant_acc.be     = grant_d ? d_be    : 4'hF;
        grant_acc.addr   = grant_d ? d_addr  : i_addr;
        grant_acc.wdata  = grant_d ? d_wdata : 32'h0;
    end

    assign wait_last   = (cnt == 4'd1);
    assign granted_req = acc.side_d ? d_req : i_req;

    assign m_be    = acc.be;
    assign m_addr  = acc.addr;
    assign m_wdata = acc.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_en      = 1'b0;
        m_we      = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_en      = 1'b1;
                m_we      = acc.we;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_ack     = !acc.side_d;
                d_ack     = acc.side_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            cnt     <= 4'd0;
            last_d  <= 1'b1;
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
            viol    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        acc <= grant_acc;
                    end
                end
                ISSUE: begin
                    cnt <= 4'(LAT);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (wait_last && !acc.we) begin
                        if (acc.side_d) begin
                            d_rdata <= m_rdata;
                        end else begin
                            i_rdata <= m_rdata;
                        end
                    end
                end
                DONE: begin
                    last_d <= acc.side_d;
                end
                default: ;
            endcase
            // Dropping req mid-access is flagged but the access still runs to its ack.
            if ((state == ISSUE || state == WAIT) && !granted_req) begin
                viol <= 1'b1;
            end
        end
    end

endmodule
